// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for the sync_fifo_param block.
// Holds the default parameter values and the log2 helper used to size
// the pointers and occupancy counter.
package sync_fifo_param_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_AE_LEVEL   = 1;

    // Smallest r with 2**r >= value. DEPTH is a power of two, so this is
    // exactly log2(DEPTH).
    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_param_fifo_mem.sv
// fifo_mem: simple dual-port register array, DATA_WIDTH x DEPTH.
// Latency: write visible to a read one edge later; read data registered, 1 cycle.
// Backpressure: none; the caller qualifies both enables.
//
// Ports:
//   clk        clock
//   wr_en_i    write strobe, stores wr_data_i at wr_addr_i
//   rd_en_i    read strobe, loads mem[rd_addr_i] into rd_data_o
//   rd_data_o  registered read data; holds when rd_en_i is low
// No reset: contents and the output register start undefined.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy and error flags.
// Latency: write-to-read 1 cycle; read data and rd_valid registered, 1 cycle.
// Backpressure: writes dropped when full (overflow), reads dropped when empty (underflow).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en, data_in       write request and data
//   rd_en                read request
//   flush                synchronous empty, overrides wr_en/rd_en
//   clr_err              synchronous clear of overflow/underflow
//   data_out, rd_valid   registered read data and its one-cycle strobe
//   full, empty, almost_full, almost_empty, count   status from the registered count
//   overflow, underflow  sticky error flags
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic                           rd_en,
    input  logic                           flush,
    input  logic                           clr_err,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           rd_valid,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [log2_ceil(DEPTH):0]      count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int ADDR_W = log2_ceil(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  AE_CNT   = CNT_W'(AE_LEVEL);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    // The memory's output register has no reset; this bit masks it to zero
    // until the first accepted read after reset loads a real word.
    logic              data_seen_q, data_seen_d;

    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // Status decodes of the registered count.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

    // Acceptance from pre-edge flags. With these rules the two ports never
    // address the same entry in one cycle: equal pointers mean empty or full,
    // and each of those blocks one side.
    assign wr_acc = wr_en & ~full  & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = rd_acc;
        data_seen_d = data_seen_q | rd_acc;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end

        // Sticky errors: a new rejection wins over a coincident clear.
        overflow_d  = (overflow_q  & ~clr_err) | (wr_en & full  & ~flush);
        underflow_d = (underflow_q & ~clr_err) | (rd_en & empty & ~flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            data_seen_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            data_seen_q <= data_seen_d;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_mem (
        .clk        (clk),
        .wr_en_i    (wr_acc),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (data_in),
        .rd_en_i    (rd_acc),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (mem_rd_data)
    );

    assign data_out  = data_seen_q ? mem_rd_data : '0;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: vector table for fill/drain, directed corner
// sequences, randomized traffic against a queue model, async reset and a
// second 12x16 instance for the wider/deeper fill.
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int AF = DP - 1;
    localparam int AE = 1;

    localparam int DW2 = 12;
    localparam int DP2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1 (8x8)
    logic          rst_n, wr_en, rd_en, flush, clr_err;
    logic [DW-1:0] data_in, data_out;
    logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]    count;

    // Instance 2 (12x16)
    logic           rst2_n, wr_en2, rd_en2, flush2, clr_err2;
    logic [DW2-1:0] data_in2, data_out2;
    logic           rd_valid2, full2, empty2, almost_full2, almost_empty2, overflow2, underflow2;
    logic [4:0]     count2;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .data_out(data_out), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_WIDTH(DW2), .DEPTH(DP2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .wr_en(wr_en2), .data_in(data_in2), .rd_en(rd_en2),
        .flush(flush2), .clr_err(clr_err2), .data_out(data_out2), .rd_valid(rd_valid2),
        .full(full2), .empty(empty2), .almost_full(almost_full2), .almost_empty(almost_empty2),
        .count(count2), .overflow(overflow2), .underflow(underflow2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus the visible registers.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_dout;
    logic          m_rv, m_ovf, m_udf;

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        check("count",        32'(count),        32'(n));
        check("full",         32'(full),         32'(n == DP));
        check("empty",        32'(empty),        32'(n == 0));
        check("almost_full",  32'(almost_full),  32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("data_out",     32'(data_out),     32'(m_dout));
        check("rd_valid",     32'(rd_valid),     32'(m_rv));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
    endtask

    // One clock of stimulus: drive after the falling edge, advance the model
    // using the occupancy before the edge, compare 1 time unit after it.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic c);
        int  n;
        logic is_full, is_empty;
        @(negedge clk);
        wr_en = w; data_in = d; rd_en = r; flush = f; clr_err = c;
        n        = mq.size();
        is_full  = (n == DP);
        is_empty = (n == 0);
        m_ovf = (m_ovf & ~c) | (w & is_full  & ~f);
        m_udf = (m_udf & ~c) | (r & is_empty & ~f);
        if (f) begin
            mq.delete();
            m_rv = 1'b0;
        end else begin
            if (r && !is_empty) begin
                m_dout = mq.pop_front();
                m_rv   = 1'b1;
            end else begin
                m_rv = 1'b0;
            end
            if (w && !is_full) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic          wr;
        logic [DW-1:0] din;
        logic          rd;
        logic          fl;
        logic          clr;
        int            cnt;
        logic [DW-1:0] dout;
        logic          rv;
        logic          full;
        logic          afull;
        logic          ovf;
        logic          udf;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [DW-1:0] saved;
        logic [DW2-1:0] v2;

        // Fill: 0x01..0x08, then a 9th write into a full FIFO.
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{wr:1'b1, din:DW'(i + 1), rd:1'b0, fl:1'b0, clr:1'b0, cnt:i + 1,
                       dout:'0, rv:1'b0, full:(i == 7), afull:(i >= 6), ovf:1'b0, udf:1'b0};
        end
        tbl[8] = '{wr:1'b1, din:8'h09, rd:1'b0, fl:1'b0, clr:1'b0, cnt:8,
                   dout:'0, rv:1'b0, full:1'b1, afull:1'b1, ovf:1'b1, udf:1'b0};
        // Drain: 0x01..0x08 in order.
        for (int k = 0; k < 8; k++) begin
            tbl[9 + k] = '{wr:1'b0, din:'0, rd:1'b1, fl:1'b0, clr:1'b0, cnt:7 - k,
                           dout:DW'(k + 1), rv:1'b1, full:1'b0, afull:(k == 0), ovf:1'b1, udf:1'b0};
        end
        // Read on empty, then clear the errors.
        tbl[17] = '{wr:1'b0, din:'0, rd:1'b1, fl:1'b0, clr:1'b0, cnt:0,
                    dout:8'h08, rv:1'b0, full:1'b0, afull:1'b0, ovf:1'b1, udf:1'b1};
        tbl[18] = '{wr:1'b0, din:'0, rd:1'b0, fl:1'b0, clr:1'b1, cnt:0,
                    dout:8'h08, rv:1'b0, full:1'b0, afull:1'b0, ovf:1'b0, udf:1'b0};

        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = '0;
        rst2_n = 1'b0; wr_en2 = 1'b0; rd_en2 = 1'b0; flush2 = 1'b0; clr_err2 = 1'b0; data_in2 = '0;
        model_reset();

        // Reset state while reset is held.
        #12;
        compare_all();
        @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        idle();

        // Table-driven fill / drain.
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].fl, tbl[i].clr);
            check($sformatf("tbl%0d_count", i), 32'(count),     32'(tbl[i].cnt));
            check($sformatf("tbl%0d_dout",  i), 32'(data_out),  32'(tbl[i].dout));
            check($sformatf("tbl%0d_rv",    i), 32'(rd_valid),  32'(tbl[i].rv));
            check($sformatf("tbl%0d_full",  i), 32'(full),      32'(tbl[i].full));
            check($sformatf("tbl%0d_afull", i), 32'(almost_full), 32'(tbl[i].afull));
            check($sformatf("tbl%0d_ovf",   i), 32'(overflow),  32'(tbl[i].ovf));
            check($sformatf("tbl%0d_udf",   i), 32'(underflow), 32'(tbl[i].udf));
        end

        // Wrap-around: pointers offset by 5, then a full pass of 0xA0..0xA7.
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        check("wrap_count8", 32'(count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("wrap_dout", 32'(data_out), 32'(8'hA0 + i));
        end

        // Concurrent read+write at count=3.
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
            check("rw3_count", 32'(count), 32'd3);
        end

        // Concurrent at full: read wins, write rejected.
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        check("rwfull_count", 32'(count), 32'd7);
        check("rwfull_ovf",   32'(overflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Concurrent at empty: write wins, read rejected.
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        check("rwempty_count", 32'(count), 32'd1);
        check("rwempty_udf",   32'(underflow), 32'd1);
        check("rwempty_rv",    32'(rd_valid), 32'd0);

        // Flush at count=5 with both requests high.
        for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        check("preflush_count", 32'(count), 32'd5);
        saved = data_out;
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_dout",  32'(data_out), 32'(saved));
        check("flush_udf",   32'(underflow), 32'd1);
        check("flush_rv",    32'(rd_valid), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 32'd0);
        check("clr_udf", 32'(underflow), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
        end

        // Async reset mid-burst, between edges.
        for (int i = 0; i < 9; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'($urandom), 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_count",    32'(count),        32'd0);
        check("arst_empty",    32'(empty),        32'd1);
        check("arst_full",     32'(full),         32'd0);
        check("arst_aempty",   32'(almost_empty), 32'd1);
        check("arst_afull",    32'(almost_full),  32'd0);
        check("arst_dout",     32'(data_out),     32'd0);
        check("arst_rv",       32'(rd_valid),     32'd0);
        check("arst_ovf",      32'(overflow),     32'd0);
        check("arst_udf",      32'(underflow),    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("post_arst_dout", 32'(data_out), 32'h77);

        // Wider/deeper instance: fill 16, full only at 16, drain in order.
        for (int i = 0; i < DP2; i++) begin
            @(negedge clk);
            v2 = DW2'(12'h101 * (i + 1));
            wr_en2 = 1'b1; data_in2 = v2;
            @(posedge clk);
            #1;
            check("w2_count", 32'(count2), 32'(i + 1));
            check("w2_full",  32'(full2),  32'(i == DP2 - 1));
        end
        @(negedge clk);
        wr_en2 = 1'b0; rd_en2 = 1'b1;
        for (int i = 0; i < DP2; i++) begin
            @(posedge clk);
            #1;
            check("r2_dout", 32'(data_out2), 32'(DW2'(12'h101 * (i + 1))));
            check("r2_rv",   32'(rd_valid2), 32'd1);
        end
        @(negedge clk);
        rd_en2 = 1'b0;
        check("r2_empty", 32'(empty2), 32'd1);
        check("r2_udf",   32'(underflow2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next-generation buffer for byte/word streams between producer and consumer logic in the same clock domain. It generalises data width and depth, supports simultaneous read and write in one cycle, and exposes an occupancy count, programmable almost-full/almost-empty flags, a read-data-valid strobe, a synchronous flush and sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per entry; legal range is 1 or more.
- DEPTH, 8: number of entries; must be a power of two, 2 or more.
- AF_LEVEL, DEPTH-1: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL.
- ADDR_W is derived, equal to log2(DEPTH). It is not user-set.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; the block leaves reset synchronously on the first clk edge after deassertion.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- flush  in  1  synchronous empty; takes priority over wr_en and rd_en.
- clr_err  in  1  synchronous clear of overflow and underflow.
- data_out  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  data_out was updated by a read accepted on the previous edge.
- full, empty, almost_full, almost_empty  out  1  status flags.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), data_out=0, rd_valid=0, overflow=0, underflow=0, and both pointers 0. Memory contents are not reset.
- Acceptance is decided from the flags before the edge:
  - wr_acc = wr_en & !full & !flush
  - rd_acc = rd_en & !empty & !flush
- An accepted write stores data_in at mem[wr_ptr] and increments wr_ptr by 1, modulo DEPTH.
- An accepted read loads mem[rd_ptr] into data_out, increments rd_ptr by 1 modulo DEPTH, and sets rd_valid=1 for one cycle. When no read is accepted, data_out holds its value and rd_valid=0.
- Count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Simultaneous read and write:
  - Not full and not empty: both are accepted and count is unchanged.
  - Full: the read is accepted and the write is rejected.
  - Empty: the write is accepted and the read is rejected. There is no fall-through.
- Rejected requests: overflow is set by wr_en & full & !flush, and underflow by rd_en & empty & !flush. Both flags hold until clr_err or reset; when set and clr_err coincide, set wins.
- Flush sets pointers and count to 0 and rd_valid to 0. data_out holds its value and the error flags are unaffected.
- All flags are combinational decodes of the registered count: full=(count==DEPTH), empty=(count==0).
- Reset asserted mid-operation immediately forces all reset values. Any in-flight data is lost.

## Timing
- Write-to-read latency: a word written at edge N is readable at edge N+1, where rd_en is sampled. It appears on data_out after that edge.
- Read latency: 1 cycle. rd_en is sampled at edge N; data_out and rd_valid are valid after edge N and remain so until edge N+1.
- Flags and count reflect every accepted operation immediately after the edge at which it was accepted.
- Sustained throughput is one write and one read per cycle when the FIFO is neither empty nor full.

## Structure
- Shared package or include file holds:
  - the log2 helper function used to derive ADDR_W;
  - the default parameter constants.
- Sub-module fifo_mem: a simple dual-port register array, DATA_WIDTH x DEPTH, with one synchronous write port and one synchronous read port with a registered output. It has no reset.
- The top level holds the pointers, count, flag decode, error flags and rd_valid.

## Test plan
All scenarios use DATA_WIDTH=8 and DEPTH=8 unless stated otherwise.
- Reset and fill: write 0x01..0x08 on 8 consecutive cycles. Response:
  - full=1 and count=8 after the 8th edge;
  - almost_full asserts after the 7th edge;
  - a 9th write sets overflow=1 and leaves contents unchanged.
- Drain: read 8 times. data_out shows 0x01..0x08 in order, with rd_valid high on each. empty=1 afterwards. A further read sets underflow=1, rd_valid stays 0, and data_out holds 0x08.
- Wrap-around: write 5 words, read 5, then write 0xA0..0xA7 and read them back. Values come out in order, and count passes through 8 with no corruption.
- Simultaneous read and write:
  - at count=3, 10 cycles of concurrent write and read keep count at 3 and return the stream in order;
  - at full, a concurrent write and read gives count=7 with overflow=1;
  - at empty, a concurrent write and read gives count=1 with underflow=1.
- Flush and clr_err: at count=5 with wr_en=1 and rd_en=1, assert flush. Response: count=0, empty=1, data_out unchanged, error flags unchanged. Then assert clr_err, and overflow and underflow go to 0.
- Async reset: drop rst_n mid-burst, between clock edges. All outputs reach their reset values without waiting for an edge. Repeat the fill with DEPTH=16 and DATA_WIDTH=12, and check full at count=16.
